buzzer_driver: RTL and testbench

Converts the 16-bit tone word produced by the auto-play music player (Hz value, 0 = rest) into a square wave for the passive buzzer pin. It computes the half-period with an iterative sequential divider and toggles the output phase-continuously. On a change of tone, the new pitch is applied at the next output edge. Sits between the player/keyboard tone mux and the board's buzzer output.

---
 rtl/buzzer_driver.sv | 128 ++++++++++++
 tb/tb_buzzer_driver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_driver.sv
// Tone-word to square-wave converter for a passive buzzer: a bit-serial divider
// turns Hz into a half-period, and the output switches pitch only on its own edges.
module buzzer_driver #(
    parameter int CLK_HZ = 12_000_000,
    parameter int MIN_HZ = 20,
    parameter int MAX_HZ = 20_000,
    parameter int DIV_W  = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] tone,
    input  logic        mute,
    output logic        beep,
    output logic        active,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, DIV, LOAD} state_t;

    localparam logic [15:0]      MIN_T    = 16'(MIN_HZ);
    localparam logic [15:0]      MAX_T    = 16'(MAX_HZ);
    localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_HZ);
    localparam int               CW       = $clog2(DIV_W);
    localparam logic [CW-1:0]    LAST_BIT = CW'(DIV_W - 1);

    state_t           state;
    logic [15:0]      tone_q;
    logic [15:0]      cur_tone;
    logic [16:0]      divisor;
    logic [16:0]      rem;
    logic [DIV_W-1:0] dvd;
    logic [DIV_W-1:0] quo;
    logic [CW-1:0]    cnt;
    logic [DIV_W-1:0] pending_hp;
    logic [DIV_W-1:0] hp;
    logic [DIV_W-1:0] hc;

    logic             tone_valid;
    logic [17:0]      rem_shift;
    logic             fits;
    logic [16:0]      rem_next;
    logic [DIV_W-1:0] quo_next;

    assign tone_valid = (tone_q >= MIN_T) && (tone_q <= MAX_T);

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    assign rem_shift = {rem, dvd[DIV_W-1]};
    assign fits      = rem_shift >= {1'b0, divisor};
    assign rem_next  = fits ? 17'(rem_shift - {1'b0, divisor}) : rem_shift[16:0];
    assign quo_next  = {quo[DIV_W-2:0], fits};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tone_q     <= '0;
            cur_tone   <= '0;
            divisor    <= '0;
            rem        <= '0;
            dvd        <= '0;
            quo        <= '0;
            cnt        <= '0;
            pending_hp <= '0;
            busy       <= 1'b0;
        end else begin
            tone_q <= tone;
            case (state)
                IDLE: begin
                    if (tone_q != cur_tone) begin
                        cur_tone <= tone_q;
                        if (tone_valid) begin
                            state   <= DIV;
                            busy    <= 1'b1;
                            divisor <= {tone_q, 1'b0};
                            rem     <= '0;
                            dvd     <= DIVIDEND;
                            quo     <= '0;
                            cnt     <= '0;
                        end else begin
                            pending_hp <= '0;
                        end
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    dvd <= {dvd[DIV_W-2:0], 1'b0};
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                    // Final bit: pending_hp is visible during LOAD, so a silent
                    // output can start on the edge that leaves LOAD.
                    if (cnt == LAST_BIT) begin
                        state      <= LOAD;
                        busy       <= 1'b0;
                        pending_hp <= (quo_next == '0) ? DIV_W'(1) : quo_next;
                    end
                end
                LOAD:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output generator: active doubles as the "currently toggling" flag, so a
    // silent or muted output restarts cleanly from beep=1 with hc at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp     <= '0;
            hc     <= '0;
            beep   <= 1'b0;
            active <= 1'b0;
        end else if (mute) begin
            hp     <= pending_hp;
            hc     <= '0;
            beep   <= 1'b0;
            active <= 1'b0;
        end else if (!active) begin
            hp     <= pending_hp;
            hc     <= '0;
            beep   <= (pending_hp != '0);
            active <= (pending_hp != '0);
        end else if (hc == hp - 1'b1) begin
            hc     <= '0;
            hp     <= pending_hp;
            beep   <= (pending_hp != '0) && !beep;
            active <= (pending_hp != '0);
        end else begin
            hc <= hc + 1'b1;
        end
    end
endmodule

// File: tb/tb_buzzer_driver.sv
// Directed bench for buzzer_driver with a cycle-level behavioural model that
// computes half-periods by plain division and tracks output levels by countdown.
module tb_buzzer_driver;
    localparam int TB_CLK_HZ = 12_000;
    localparam int TB_MIN_HZ = 20;
    localparam int TB_MAX_HZ = 20_000;
    localparam int TB_DIV_W  = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        mute  = 1'b0;
    logic [15:0] tone  = '0;
    logic        beep;
    logic        active;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    buzzer_driver #(
        .CLK_HZ(TB_CLK_HZ),
        .MIN_HZ(TB_MIN_HZ),
        .MAX_HZ(TB_MAX_HZ),
        .DIV_W (TB_DIV_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tone  (tone),
        .mute  (mute),
        .beep  (beep),
        .active(active),
        .busy  (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model ----------------
    int m_tone_q = 0, m_cur = 0, m_pend = 0, m_left = 0;
    int m_div_left = 0, m_result = 0;
    bit m_beep = 0, m_active = 0, m_busy = 0, m_load = 0;

    function automatic int half_period(input int hz);
        int q;
        q = TB_CLK_HZ / (2 * hz);
        return (q == 0) ? 1 : q;
    endfunction

    initial begin
        int o_tq, o_pend;
        bit o_active;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_tone_q = 0; m_cur = 0; m_pend = 0; m_left = 0;
                m_div_left = 0; m_result = 0;
                m_beep = 0; m_active = 0; m_busy = 0; m_load = 0;
            end else begin
                o_tq = m_tone_q; o_pend = m_pend; o_active = m_active;
                // output level: clocks left in the current level, reloaded at each edge
                if (mute) begin
                    m_beep = 0; m_active = 0; m_left = 0;
                end else if (!o_active) begin
                    if (o_pend != 0) begin
                        m_beep = 1; m_active = 1; m_left = o_pend;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_left = o_pend;
                        if (o_pend == 0) begin
                            m_beep = 0; m_active = 0;
                        end else begin
                            m_beep = !m_beep;
                        end
                    end
                end
                // tone tracking: DIV_W busy cycles, then one load cycle
                if (m_load) begin
                    m_load = 0;
                end else if (m_div_left > 0) begin
                    m_div_left--;
                    if (m_div_left == 0) begin
                        m_pend = m_result; m_busy = 0; m_load = 1;
                    end
                end else if (o_tq != m_cur) begin
                    m_cur = o_tq;
                    if (o_tq >= TB_MIN_HZ && o_tq <= TB_MAX_HZ) begin
                        m_result = half_period(o_tq);
                        m_div_left = TB_DIV_W;
                        m_busy = 1;
                    end else begin
                        m_pend = 0;
                    end
                end
                m_tone_q = int'(tone);
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("cmp_beep", 32'(beep), 32'(m_beep));
            check("cmp_active", 32'(active), 32'(m_active));
            check("cmp_busy", 32'(busy), 32'(m_busy));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clocks the current beep level lasts, starting at the first cycle of that level.
    task automatic phase_len(input int limit, output int len);
        logic v;
        v = beep;
        len = 0;
        while (beep === v && len < limit) begin
            @(negedge clk);
            len++;
        end
    endtask

    task automatic sync_edge(input int limit);
        int dummy;
        phase_len(limit, dummy);
    endtask

    task automatic count_busy(input int n, output int high, output int rises, output int beeps);
        logic prev;
        high = 0; rises = 0; beeps = 0;
        prev = busy;
        repeat (n) begin
            @(negedge clk);
            if (busy === 1'b1) high++;
            if (busy === 1'b1 && prev !== 1'b1) rises++;
            if (beep === 1'b1) beeps++;
            prev = busy;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int e, waited, busy_cnt, hi, lo, rises, beeps;
        int ph[6];

        tick(3);
        check("reset_beep", 32'(beep), 0);
        check("reset_active", 32'(active), 0);
        check("reset_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick(2);

        // start 1000 Hz from silence: hp = 12000/2000 = 6
        e = cyc;
        tone = 16'd1000;
        busy_cnt = 0;
        waited = 0;
        while (beep !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
            if (busy === 1'b1) busy_cnt++;
        end
        check("first_rise_cycle", 32'(cyc - e), 19);
        check("busy_cycles", 32'(busy_cnt), 16);
        phase_len(40, hi);
        phase_len(40, lo);
        check("hp1000_high", 32'(hi), 6);
        check("hp1000_low", 32'(lo), 6);

        // switch to 500 Hz right after a rising edge: four more 6-clock phases, then 12
        tone = 16'd500;
        for (int i = 0; i < 6; i++) phase_len(40, ph[i]);
        for (int i = 0; i < 4; i++) check($sformatf("switch_old_phase%0d", i), 32'(ph[i]), 6);
        check("switch_new_phase4", 32'(ph[4]), 12);
        check("switch_new_phase5", 32'(ph[5]), 12);

        // rest: takes effect at the next edge, 12 clocks into the current phase
        tone = 16'd0;
        waited = 0;
        while (active !== 1'b0 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check("rest_edge_delay", 32'(waited), 12);
        check("rest_beep_low", 32'(beep), 0);

        // below MIN_HZ is a rest: no division, no sound
        tone = 16'd15;
        count_busy(30, busy_cnt, rises, beeps);
        check("low_tone_busy", 32'(busy_cnt), 0);
        check("low_tone_beep", 32'(beeps), 0);

        // 1000 -> 2000 -> 1500 inside one division window: final hp = 12000/3000
        tone = 16'd1000;
        tick(4);
        tone = 16'd2000;
        tick(4);
        tone = 16'd1500;
        count_busy(70, busy_cnt, rises, beeps);
        check("last_wins_div_count", 32'(rises), 1);
        sync_edge(40);
        phase_len(40, hi);
        phase_len(40, lo);
        check("last_wins_phase_a", 32'(hi), 4);
        check("last_wins_phase_b", 32'(lo), 4);

        // 3-clock mute pulse
        mute = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("mute_beep%0d", i), 32'(beep), 0);
            check($sformatf("mute_active%0d", i), 32'(active), 0);
        end
        mute = 1'b0;
        @(negedge clk);
        check("unmute_beep_high", 32'(beep), 1);
        phase_len(40, hi);
        check("unmute_full_phase", 32'(hi), 4);

        // reset in the middle of a division, then the same tone recomputes
        tone = 16'd500;
        tick(8);
        check("pre_reset_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_beep", 32'(beep), 0);
        check("async_reset_active", 32'(active), 0);
        check("async_reset_busy", 32'(busy), 0);
        tick(2);
        rst_n = 1'b1;
        waited = 0;
        while (busy !== 1'b1 && waited < 6) begin
            @(negedge clk);
            waited++;
        end
        check("post_reset_busy_delay", 32'(waited), 2);
        tick(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
